// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int BYTE_W       = 8;
    localparam int DEF_GAP_CYC  = 16;
    localparam int DEF_WDOG_CYC = 200000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner select: the search starts one past last_owner and wraps.
// Pure combinational; valid is high whenever any request is present.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_owner,
    output logic [NREQ-1:0]         winner,
    output logic                    valid
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_owner) + k) % NREQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters: gnt one cycle after req, newd one cycle after gnt.
// Optional SEND watchdog with sticky per-requester error flags under UART_TX_ARB_WDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int WDOG_CYC = DEF_WDOG_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [BYTE_W*NREQ-1:0] din,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [BYTE_W-1:0]      dintx,
    output logic                   newd,
    input  logic                   donetx,
    output logic                   busy,
    output logic [NREQ-1:0]        err
);

    localparam int IW = $clog2(NREQ);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    arb_state_t        state, state_nxt;
    logic [IW-1:0]     last_owner, owner, win_idx;
    logic [NREQ-1:0]   win;
    logic              win_vld;
    logic [BYTE_W-1:0] din_sel;
    logic              donetx_q, dtx_rise, wd_to;
    logic [GW-1:0]     gap_cnt;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (win),
        .valid      (win_vld)
    );

    always_comb begin
        win_idx = '0;
        din_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = IW'(i);
                din_sel = din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // A donetx level already high when SEND starts has donetx_q high too, so it never counts.
    assign dtx_rise = donetx & ~donetx_q;
    assign newd     = (state == SEND);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (dtx_rise || wd_to) state_nxt = GAP;
            GAP:     if (gap_cnt == GW'(GAP_CYC - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= IW'(NREQ - 1);
            owner      <= '0;
            dintx      <= '0;
            gnt        <= '0;
            done       <= '0;
            donetx_q   <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            donetx_q <= donetx;
            gnt      <= '0;
            done     <= '0;
            if (state == IDLE && win_vld) begin
                gnt        <= win;
                owner      <= win_idx;
                last_owner <= win_idx;
                dintx      <= din_sel;
            end
            if (state == SEND && dtx_rise) done <= NREQ'(1) << owner;
            if (state == GAP) begin
                if (gap_cnt != GW'(GAP_CYC - 1)) gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

`ifdef UART_TX_ARB_WDOG_EN
    localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    logic [WW-1:0] wd_cnt;

    // A completion edge on the final allowed cycle still wins over the timeout.
    assign wd_to = (state == SEND) && !dtx_rise && (wd_cnt == WW'(WDOG_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err    <= '0;
        end else begin
            if (state == SEND) begin
                if (wd_cnt != WW'(WDOG_CYC - 1)) wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_to) err <= err | (NREQ'(1) << owner);
        end
    end
`else
    assign wd_to = 1'b0;
    assign err   = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded random bench: batches of queued bytes, round-robin order predicted at load time.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int WDOG = 100;

    logic clk = 1'b0, rst = 1'b0, donetx = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] din = '0;
    logic [NREQ-1:0]   gnt, done, err;
    logic [7:0]        dintx;
    logic              newd, busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .done(done),
        .dintx(dintx), .newd(newd), .donetx(donetx), .busy(busy), .err(err)
    );

    typedef struct { int idx; logic [7:0] b; } exp_t;
    exp_t       exp_q[$];
    int         total = 0, bad = 0, cyc = 0;
    int         m_last = NREQ - 1;
    int         load_cyc = 0, tx_mode = 0;
    bit         batch_first = 0, edge_given = 0, tx_busy = 0, outst = 0;
    logic [7:0] rq_b [NREQ][8];
    int         rq_h [NREQ], rq_n [NREQ], ld_n [NREQ];
    logic [7:0] ld_b [NREQ][8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic update_bus();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (rq_n[i] > 0);
            din[i*8 +: 8] = (rq_n[i] > 0) ? rq_b[i][rq_h[i]] : 8'($urandom);
        end
    endtask

    // Reference model: serve pending queues one byte at a time, starting one past the last winner.
    task automatic load_batch();
        int left[NREQ], pos[NREQ], any, i;
        bit found;
        for (int r = 0; r < NREQ; r++) begin
            left[r] = ld_n[r]; pos[r] = 0; rq_h[r] = 0; rq_n[r] = ld_n[r];
            for (int j = 0; j < 8; j++) rq_b[r][j] = ld_b[r][j];
        end
        any = 1;
        while (any != 0) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                i = (m_last + k) % NREQ;
                if (!found && left[i] > 0) begin
                    exp_q.push_back('{idx: i, b: rq_b[i][pos[i]]});
                    pos[i]++; left[i]--; m_last = i; found = 1;
                end
            end
            any = 0;
            for (int r = 0; r < NREQ; r++) any += left[r];
        end
        batch_first = 1;
        load_cyc    = cyc;
        update_bus();
    endtask

    task automatic wait_batch(input string name);
        bit fin = 0;
        int pend;
        for (int n = 0; n < 4000 && !fin; n++) begin
            @(posedge clk); #1;
            pend = 0;
            for (int r = 0; r < NREQ; r++) pend += rq_n[r];
            if (exp_q.size() == 0 && !busy && !tx_busy && pend == 0) fin = 1;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL %s: batch not finished within cycle budget, %0d frames left", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_outstanding"}, 32'(outst), 0);
    endtask

    // Requesters: drop the granted byte, keep req up if more remain.
    initial begin : requesters
        logic [NREQ-1:0] g;
        forever begin
            @(negedge clk);
            if (rst && gnt != '0) begin
                g = gnt;
                @(posedge clk); #1;
                for (int i = 0; i < NREQ; i++)
                    if (g[i] && rq_n[i] > 0) begin rq_h[i]++; rq_n[i]--; end
                update_bus();
            end
        end
    end

    // Transmitter model: 0 = normal completion pulse, 1 = donetx already high, 2 = never completes.
    initial begin : transmitter
        int d;
        forever begin
            @(negedge clk);
            if (rst && newd) begin
                tx_busy = 1;
                @(posedge clk); #1;
                edge_given = 0;
                if (tx_mode == 0) begin
                    d = $urandom_range(1, 12);
                    repeat (d) @(posedge clk);
                    #1; edge_given = 1; donetx = 1;
                    d = $urandom_range(1, 3);
                    repeat (d) @(posedge clk);
                    #1; donetx = 0;
                end else if (tx_mode == 1) begin
                    repeat (5) @(posedge clk);
                    #1; donetx = 0;
                    repeat (2) @(posedge clk);
                    #1; edge_given = 1; donetx = 1;
                    @(posedge clk); #1; donetx = 0;
                end
                for (int n = 0; n < 5000 && newd && rst; n++) @(negedge clk);
                tx_busy = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every grant and checks framing, completion and spacing.
    initial begin : monitor
        logic [NREQ-1:0] prev_err;
        logic [7:0]      exp_b;
        bit              prev_gnt, prev_newd, in_gap;
        int              owner, hi_cnt, gap_cnt;
        exp_t            e;
        prev_err = '0; exp_b = '0; prev_gnt = 0; prev_newd = 0; in_gap = 0;
        owner = 0; hi_cnt = 0; gap_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                outst = 0; prev_gnt = 0; prev_newd = 0; in_gap = 0; hi_cnt = 0; prev_err = '0;
            end else begin
                if (gnt != '0) begin
                    if (exp_q.size() == 0) chk("unexpected_gnt", 32'(gnt), 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("gnt_onehot", 32'(gnt), 32'(1) << e.idx);
                        chk("gnt_dintx", 32'(dintx), 32'(e.b));
                        if (batch_first) begin
                            chk("gnt_latency", cyc - load_cyc, 1);
                            batch_first = 0;
                        end
                        owner = e.idx; exp_b = e.b; outst = 1;
                    end
                end
                if (prev_gnt) chk("newd_after_gnt", 32'(newd), 1);
                if (newd) begin
                    hi_cnt++;
                    chk("dintx_hold", 32'(dintx), 32'(exp_b));
                end
                if (done != '0) begin
                    chk("done_expected", 32'(outst), 1);
                    chk("done_onehot", 32'(done), 32'(1) << owner);
                    chk("done_after_edge", 32'(edge_given), 1);
                    outst = 0;
                end
                if (prev_newd && !newd) begin
                    chk("gap_busy", 32'(busy), 1);
                    if (done == '0) begin
`ifdef UART_TX_ARB_WDOG_EN
                        chk("wdog_len", hi_cnt, WDOG);
                        chk("wdog_err", 32'(err), 32'(prev_err) | (32'(1) << owner));
                        outst = 0;
`else
                        chk("newd_drop_no_done", 32'(done), 32'(1) << owner);
`endif
                    end
                    in_gap = 1; gap_cnt = 0; hi_cnt = 0;
                end
                if (in_gap) begin
                    if (busy) gap_cnt++;
                    else begin
                        chk("gap_len", gap_cnt, GAP);
                        in_gap = 0;
                    end
                end
                prev_gnt = (gnt != '0); prev_newd = newd; prev_err = err;
            end
        end
    end

    task automatic clear_ld();
        for (int r = 0; r < NREQ; r++) begin
            ld_n[r] = 0;
            for (int j = 0; j < 8; j++) ld_b[r][j] = 8'($urandom);
        end
    endtask

    initial begin : main
        int hold;
        for (int r = 0; r < NREQ; r++) begin rq_h[r] = 0; rq_n[r] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);   chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);   chk("rst_dintx", 32'(dintx), 0);
        chk("rst_newd", 32'(newd), 0); chk("rst_busy", 32'(busy), 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;

        clear_ld(); ld_n[0] = 1; ld_b[0][0] = 8'hA5;
        load_batch(); wait_batch("single");

        clear_ld();
        ld_b[0][0] = 8'h11; ld_b[1][0] = 8'h22; ld_b[2][0] = 8'h33; ld_b[3][0] = 8'h44;
        for (int r = 0; r < NREQ; r++) ld_n[r] = 1;
        load_batch(); wait_batch("all_four");

        clear_ld(); ld_n[0] = 3; ld_n[2] = 2;
        load_batch(); wait_batch("fair_0_2");

        for (int b = 0; b < 10; b++) begin
            clear_ld();
            for (int r = 0; r < NREQ; r++) ld_n[r] = $urandom_range(0, 3);
            if (ld_n[0] + ld_n[1] + ld_n[2] + ld_n[3] == 0) ld_n[$urandom_range(0, NREQ - 1)] = 1;
            load_batch(); wait_batch("random");
        end

        tx_mode = 1; donetx = 1;
        clear_ld(); ld_n[1] = 1;
        load_batch(); wait_batch("donetx_prehigh");
        tx_mode = 0; donetx = 0;

`ifdef UART_TX_ARB_WDOG_EN
        tx_mode = 2;
        clear_ld(); ld_n[3] = 1;
        load_batch(); wait_batch("watchdog");
        chk("wdog_err_sticky", 32'(err[3]), 1);
        hold = 40;
`else
        hold = 300;
`endif

        tx_mode = 2;
        clear_ld(); ld_n[1] = 1;
        load_batch();
        for (int n = 0; n < 50 && !newd; n++) begin @(posedge clk); #1; end
        repeat (hold) @(posedge clk);
        #1;
        chk("send_busy", 32'(busy), 1);
        chk("send_newd", 32'(newd), 1);
        rst = 0;
        #1;
        chk("midrst_newd", 32'(newd), 0); chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0); chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_err", 32'(err), 0);   chk("midrst_dintx", 32'(dintx), 0);
        exp_q.delete();
        m_last = NREQ - 1;
        for (int r = 0; r < NREQ; r++) rq_n[r] = 0;
        update_bus();
        tx_mode = 0; donetx = 0;
        repeat (3) @(posedge clk);
        #1; rst = 1;
        repeat (6) @(posedge clk);
        #1;
        clear_ld();
        for (int r = 0; r < NREQ; r++) ld_n[r] = 1;
        load_batch(); wait_batch("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end
endmodule
